// File: rtl/ifid_if.sv
// Handshake and data bundle between the fetch stage, the IF/ID latch and decode.
interface ifid_if;
  logic [31:0] npc;
  logic [31:0] instr;
  logic        if_valid;
  logic        id_ready;
  logic        flush;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic [31:0] npcout;
  logic [31:0] instrout;
  logic        id_valid;
  logic        if_ready;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output npc, instr, if_valid, id_ready, flush, ex_memread, ex_rt,
    input  npcout, instrout, id_valid, if_ready, stall_cnt, flush_cnt
  );

  modport slave (
    input  npc, instr, if_valid, id_ready, flush, ex_memread, ex_rt,
    output npcout, instrout, id_valid, if_ready, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ifid_ctrl.sv
// IF/ID pipeline latch with load-use bubble insertion, branch flush and
// saturating stall/flush event counters.
module ifid_ctrl (
  input  logic   clk,
  input  logic   rst,
  ifid_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, FULL, HAZ} state_t;

  state_t      state, state_n;
  logic [31:0] npc_q, npc_n;
  logic [31:0] instr_q, instr_n;
  logic [15:0] stall_q, flush_q;
  logic        stall_inc, flush_inc;
  logic        hazard;
  logic        id_valid, if_ready;

  // Load-use check against the held instruction's rs/rt fields; masked in HAZ
  // so the same instruction only ever costs one bubble.
  assign hazard = (state == FULL) && bus.ex_memread && (bus.ex_rt != 5'd0) &&
                  ((bus.ex_rt == instr_q[25:21]) || (bus.ex_rt == instr_q[20:16]));

  assign id_valid = ((state == FULL) && !hazard) || (state == HAZ);
  assign if_ready = !bus.flush && ((state == EMPTY) || (id_valid && bus.id_ready));

  always_comb begin
    state_n   = state;
    npc_n     = npc_q;
    instr_n   = instr_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (bus.flush) begin
      state_n   = EMPTY;
      npc_n     = 32'd0;
      instr_n   = 32'd0;
      flush_inc = (state != EMPTY);
    end else begin
      unique case (state)
        EMPTY: begin
          if (bus.if_valid) begin
            state_n = FULL;
            npc_n   = bus.npc;
            instr_n = bus.instr;
          end
        end
        FULL, HAZ: begin
          if (hazard) begin
            state_n   = HAZ;
            stall_inc = 1'b1;
          end else if (bus.id_ready) begin
            if (bus.if_valid) begin
              state_n = FULL;
              npc_n   = bus.npc;
              instr_n = bus.instr;
            end else begin
              state_n = EMPTY;
            end
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      npc_q   <= 32'd0;
      instr_q <= 32'd0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state   <= state_n;
      npc_q   <= npc_n;
      instr_q <= instr_n;
      if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_inc && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign bus.npcout    = npc_q;
  assign bus.instrout  = instr_q;
  assign bus.id_valid  = id_valid;
  assign bus.if_ready  = if_ready;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_ifid_ctrl.sv
// Self-checking bench for ifid_ctrl: directed scenarios plus random traffic,
// compared each cycle against a transaction-level model of the latch.
module tb_ifid_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ifid_if bus ();

  ifid_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checkCount = 0;
  int errCount   = 0;

  // Model: is an instruction held, has its bubble already been taken, its
  // contents, and the two event totals.
  logic        mKnown  = 1'b0;
  logic        mHeld   = 1'b0;
  logic        mMasked = 1'b0;
  logic [31:0] mNpc    = '0;
  logic [31:0] mInstr  = '0;
  logic [15:0] mStall  = '0;
  logic [15:0] mFlush  = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic modelHazard();
    return mHeld && !mMasked && bus.ex_memread && (bus.ex_rt != 5'd0) &&
           ((bus.ex_rt == mInstr[25:21]) || (bus.ex_rt == mInstr[20:16]));
  endfunction

  // Drive one cycle of inputs at the falling edge, compare every output
  // against the model, then advance the model past the coming rising edge.
  task automatic applyStimulus(input logic r, input logic ifv, input logic [31:0] pc,
                               input logic [31:0] ins, input logic idr, input logic fl,
                               input logic mr, input logic [4:0] rt);
    logic haz, issue, accept;
    @(negedge clk);
    rst            = r;
    bus.if_valid   = ifv;
    bus.npc        = pc;
    bus.instr      = ins;
    bus.id_ready   = idr;
    bus.flush      = fl;
    bus.ex_memread = mr;
    bus.ex_rt      = rt;
    #1;
    haz    = modelHazard();
    issue  = mHeld && !haz;
    accept = !fl && (!mHeld || (issue && idr));
    if (mKnown) begin
      checkOutput("npcout",    bus.npcout,            mNpc);
      checkOutput("instrout",  bus.instrout,          mInstr);
      checkOutput("id_valid",  {31'd0, bus.id_valid}, {31'd0, issue});
      checkOutput("if_ready",  {31'd0, bus.if_ready}, {31'd0, accept});
      checkOutput("stall_cnt", {16'd0, bus.stall_cnt}, {16'd0, mStall});
      checkOutput("flush_cnt", {16'd0, bus.flush_cnt}, {16'd0, mFlush});
    end
    if (r) begin
      mKnown = 1'b1; mHeld = 1'b0; mMasked = 1'b0;
      mNpc = '0; mInstr = '0; mStall = '0; mFlush = '0;
    end else if (fl) begin
      if (mHeld && mFlush != 16'hFFFF) mFlush = mFlush + 16'd1;
      mHeld = 1'b0; mNpc = '0; mInstr = '0;
    end else if (haz) begin
      if (mStall != 16'hFFFF) mStall = mStall + 16'd1;
      mMasked = 1'b1;
    end else if (accept) begin
      if (ifv) begin
        mHeld = 1'b1; mMasked = 1'b0; mNpc = pc; mInstr = ins;
      end else begin
        mHeld = 1'b0;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.if_valid = 1'b0; bus.npc = '0; bus.instr = '0; bus.id_ready = 1'b0;
    bus.flush = 1'b0; bus.ex_memread = 1'b0; bus.ex_rt = '0;

    applyStimulus(1'b1, 1'b1, 32'h99, 32'h99, 1'b1, 1'b1, 1'b0, 5'd0);
    idle();
    checkOutput("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    checkOutput("rst_if_ready", {31'd0, bus.if_ready}, 32'd1);

    // First fetch reaches decode one cycle later.
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h8C220000, 1'b1, 1'b0, 1'b0, 5'd0);
    idle();
    checkOutput("first_npc",   bus.npcout,   32'h4);
    checkOutput("first_instr", bus.instrout, 32'h8C220000);
    checkOutput("first_valid", {31'd0, bus.id_valid}, 32'd1);

    // Load-use on rs: one bubble, then released from HAZ.
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h00430820, 1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2);
    checkOutput("haz_valid", {31'd0, bus.id_valid}, 32'd0);
    checkOutput("haz_ready", {31'd0, bus.if_ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2);
    checkOutput("haz_stall", {16'd0, bus.stall_cnt}, 32'd1);
    checkOutput("haz_release", {31'd0, bus.id_valid}, 32'd1);

    // ex_rt of zero never stalls.
    applyStimulus(1'b0, 1'b1, 32'hC, 32'h00430820, 1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0);
    checkOutput("r0_valid", {31'd0, bus.id_valid}, 32'd1);
    checkOutput("r0_stall", {16'd0, bus.stall_cnt}, 32'd1);

    // Flush of a held instruction while a fetch is offered.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h00001234, 1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 32'h14, 32'h00005678, 1'b1, 1'b1, 1'b0, 5'd0);
    checkOutput("flush_ready", {31'd0, bus.if_ready}, 32'd0);
    idle();
    checkOutput("flush_instr", bus.instrout, 32'd0);
    checkOutput("flush_npc",   bus.npcout,   32'd0);
    checkOutput("flush_cnt1",  {16'd0, bus.flush_cnt}, 32'd1);

    // Decode back-pressure holds the latch while fetch keeps changing.
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h0000AAAA, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h100 + i, 32'h0BAD0000 + i, 1'b0, 1'b0, 1'b0, 5'd0);
      checkOutput("hold_npc",   bus.npcout,   32'h20);
      checkOutput("hold_instr", bus.instrout, 32'h0000AAAA);
    end

    // Random traffic; small register numbers make hazards frequent.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom, ins,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
    end

    // Preload both counters one below saturation, then push past it.
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle();
    force dut.stall_q = 16'hFFFE;
    force dut.flush_q = 16'hFFFE;
    #1;
    release dut.stall_q;
    release dut.flush_q;
    mStall = 16'hFFFE;
    mFlush = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h40, 32'h00430820, 1'b1, 1'b0, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    end
    checkOutput("sat_stall", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h44, 32'h00000001, 1'b0, 1'b0, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    end
    idle();
    checkOutput("sat_flush", {16'd0, bus.flush_cnt}, 32'h0000FFFF);

    // Reset mid-HAZ clears everything.
    applyStimulus(1'b0, 1'b1, 32'h48, 32'h00430820, 1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    applyStimulus(1'b1, 1'b1, 32'h4C, 32'h1, 1'b1, 1'b1, 1'b1, 5'd2);
    idle();
    checkOutput("rst_stall", {16'd0, bus.stall_cnt}, 32'd0);
    checkOutput("rst_flush", {16'd0, bus.flush_cnt}, 32'd0);
    checkOutput("rst_instr", bus.instrout, 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ifid_ctrl.md
IFID_CTRL -- requirements
Module: ifid_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high; sampled only at the rising edge of clk.
REQ-003 SHALL have port npc  input  32  next-PC value from the fetch stage.
REQ-004 SHALL have port instr  input  32  fetched instruction word.
REQ-005 SHALL have port if_valid  input  1  npc and instr hold a valid fetch this cycle.
REQ-006 SHALL have port id_ready  input  1  decode stage can accept the held instruction this cycle.
REQ-007 SHALL have port flush  input  1  taken branch or jump: discard the held and incoming instruction.
REQ-008 SHALL have port ex_memread  input  1  the instruction in EX is a load.
REQ-009 SHALL have port ex_rt  input  5  destination register of the load in EX.
REQ-010 SHALL have port npcout  output  32  registered next-PC presented to decode.
REQ-011 SHALL have port instrout  output  32  registered instruction presented to decode.
REQ-012 SHALL have port id_valid  output  1  instrout is issued to decode this cycle; 0 means bubble.
REQ-013 SHALL have port if_ready  output  1  the latch accepts a fetch this cycle; also serves as the PC write enable.
REQ-014 SHALL have port stall_cnt  output  16  saturating count of load-use bubble cycles.
REQ-015 SHALL have port flush_cnt  output  16  saturating count of flushes that discarded a held instruction.

Function
REQ-016 SHALL implement a 3-state FSM: EMPTY (nothing held), FULL (instruction held, hazard check active), HAZ (instruction held, hazard check masked).
REQ-017 SHALL compute hazard combinationally as: state==FULL && ex_memread && ex_rt!=0 && (ex_rt==instrout[25:21] || ex_rt==instrout[20:16]).
REQ-018 SHALL drive id_valid = (state==FULL && !hazard) || state==HAZ.
REQ-019 SHALL drive if_ready = !flush && (state==EMPTY || (id_valid && id_ready)).
REQ-020 SHALL, when flush=1, go to EMPTY next cycle, load npcout=0 and instrout=0, and take priority over every other condition.
REQ-021 SHALL, in EMPTY without flush: if if_valid, load npc/instr and go to FULL; otherwise stay in EMPTY with the outputs unchanged.
REQ-022 SHALL, in FULL with hazard=1, hold npcout/instrout, go to HAZ, and increment stall_cnt.
REQ-023 SHALL, in FULL without hazard or in HAZ, with id_ready=1: if if_valid, load the new fetch and go to FULL; otherwise go to EMPTY.
REQ-024 SHALL, in FULL without hazard or in HAZ, with id_ready=0: hold all outputs; FULL stays FULL and HAZ stays HAZ.
REQ-025 SHALL mask the hazard check in HAZ, so each load-use hazard produces exactly one bubble cycle.
REQ-026 SHALL increment flush_cnt when flush=1 and state!=EMPTY.
REQ-027 SHALL saturate both counters at 16'hFFFF, with no wrap-around.
REQ-028 SHALL, when flush and hazard occur in the same cycle, increment flush_cnt only, not stall_cnt.
REQ-029 SHALL register every output except the combinational id_valid and if_ready; npc and instr reach npcout/instrout with 1-cycle latency.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, set state=EMPTY, npcout=0, instrout=0, stall_cnt=0, flush_cnt=0.
REQ-031 SHALL give rst priority over flush and all other inputs, including mid-stall and mid-HAZ.
REQ-032 SHALL hold id_valid=0 and if_ready=1 combinationally in the cycle after reset.

Verification
REQ-033 SHALL pass this bench case: after reset, if_valid=1, npc=0x4, instr=0x8C220000, id_ready=1 -> next cycle npcout=0x4, instrout=0x8C220000, id_valid=1.
REQ-034 SHALL pass this bench case: FULL with instrout=0x00430820 (rs=2), ex_memread=1, ex_rt=2 -> id_valid=0 and if_ready=0 for 1 cycle, stall_cnt=1; next cycle HAZ, id_valid=1, hold released.
REQ-035 SHALL pass this bench case: same as REQ-034 but ex_rt=0 -> no bubble and stall_cnt stays 0.
REQ-036 SHALL pass this bench case: FULL, flush=1 with if_valid=1 -> next cycle EMPTY, instrout=0, npcout=0, flush_cnt=1, if_ready=0 during the flush cycle.
REQ-037 SHALL pass this bench case: FULL, id_ready=0 for 3 cycles with changing npc/instr -> npcout/instrout unchanged and counters unchanged.
REQ-038 SHALL pass this bench case: stall_cnt preloaded to 0xFFFF by repeated hazards -> it stays 0xFFFF on a further hazard; then rst=1 -> all counters 0.
